frame_reader: RTL

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/frame_reader.sv
// frame_reader: reads one frame of NUM_PIX pixels from a synchronous memory
// (one-cycle read latency) and streams it out on a valid/ready pixel port,
// tagging end-of-row (m_eol) and end-of-frame (m_last).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    one-cycle frame request and first frame address
//   ren, raddr, rdata   memory read port (rdata valid the cycle after ren)
//   m_valid, m_ready    output handshake
//   m_data, m_eol,
//   m_last              output pixel and its row/frame markers
//   busy, done          frame in progress / one-cycle completion pulse
module frame_reader #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 19,
  parameter int IMG_W   = 640,
  parameter int NUM_PIX = 307200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  output logic               ren,
  output logic [A_WIDTH-1:0] raddr,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_eol,
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COL_W-1:0]   col_q;

  // One read in flight plus the row/frame markers that travel with it.
  logic               fl_q, fl_eol_q, fl_last_q;

  // 2-entry pixel FIFO.
  logic [D_WIDTH-1:0] fd_q [2];
  logic [1:0]         feol_q, flast_q;
  logic               wp_q, rp_q;
  logic [1:0]         cnt_q;

  logic               start_acc, done_d, push, pop;
  logic [1:0]         occ, limit;

  assign push    = fl_q;
  assign m_valid = (cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = fd_q[rp_q];
  assign m_eol   = feol_q[rp_q];
  assign m_last  = flast_q[rp_q];
  assign raddr   = addr_q;
  assign busy    = (state_q != IDLE);

  // A slot freed by this cycle's pop can be reused by this cycle's read,
  // which is what sustains one pixel per cycle with only two entries.
  assign occ   = cnt_q + {1'b0, fl_q};
  assign limit = 2'd2 + {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    ren       = 1'b0;
    start_acc = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (occ < limit) begin
          ren = 1'b1;
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      idx_q     <= '0;
      col_q     <= '0;
      fl_q      <= 1'b0;
      fl_eol_q  <= 1'b0;
      fl_last_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fd_q[i] <= '0;
      feol_q    <= '0;
      flast_q   <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (start_acc) begin
        addr_q <= base_addr;
        idx_q  <= '0;
        col_q  <= '0;
      end else if (ren) begin
        addr_q <= addr_q + A_WIDTH'(1);
        idx_q  <= idx_q + IDX_W'(1);
        col_q  <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
      end

      fl_q      <= ren;
      fl_eol_q  <= (col_q == LAST_COL);
      fl_last_q <= (idx_q == LAST_IDX);

      if (push) begin
        fd_q[wp_q]    <= rdata;
        feol_q[wp_q]  <= fl_eol_q;
        flast_q[wp_q] <= fl_last_q;
        wp_q          <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;

      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
